// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of unsigned 32-bit products. The result is
// presented with a valid/ready handshake and held until the consumer takes it.
// A three-state FSM (Idle / Accum / Hold) sequences frame intake and result
// presentation.
// Build option: define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the sum at
// 2^ACC_WIDTH-1 on overflow. The default build wraps modulo 2^ACC_WIDTH.
// out_overflow is sticky per frame in both builds.
module product_accumulator #(
  parameter int unsigned ACC_WIDTH = 40,  // legal range 32..64
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] load_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 accept;

  // Datapath: zero-extended add with carry detect, plus a saturating term count.
  always_comb begin
    prod_ext          = '0;
    prod_ext[31:0]    = in_product;
    sum_ext           = {1'b0, acc_q} + prod_ext;
    carry             = sum_ext[ACC_WIDTH];
    load_d            = prod_ext[ACC_WIDTH-1:0];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further add carries again, so the sum stays at max.
    acc_d             = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
    acc_d             = sum_ext[ACC_WIDTH-1:0];
`endif
    cnt_d             = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid && in_ready;

  // Frame FSM and accumulator state; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q   <= load_d;
            cnt_q   <= CNT_WIDTH'(1);
            ovf_q   <= 1'b0;
            state_q <= in_last ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | carry;
            state_q <= in_last ? StHold : StAccum;
          end
        end
        StHold: begin
          // in_ready is low here, so a beat offered on the exit edge is ignored.
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Result is only visible while presented; it reads zero otherwise.
  always_comb begin
    out_valid    = (state_q == StHold);
    out_sum      = out_valid ? acc_q : '0;
    out_count    = out_valid ? cnt_q : '0;
    out_overflow = out_valid && ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (ACC_WIDTH=32, CNT_WIDTH=4).
// Expected results come from whole-frame arithmetic on the list of beats sent.
module tb_product_accumulator;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_product;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] frame_q[$];

  always #5 clk = ~clk;

  product_accumulator #(
    .ACC_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_product  (in_product),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: true sum of the frame, then wrap or clamp; overflow iff true sum exceeds max.
  task automatic model_frame(output logic [63:0] e_sum, output logic [63:0] e_cnt,
                             output logic [63:0] e_ovf);
    longint unsigned tot  = 0;
    longint unsigned maxv = (64'd1 << AW) - 1;
    foreach (frame_q[i]) tot += 64'(frame_q[i]);
    e_ovf = (tot > maxv) ? 64'd1 : 64'd0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    e_sum = (tot > maxv) ? maxv : tot;
`else
    e_sum = tot & maxv;
`endif
    e_cnt = (frame_q.size() > 15) ? 64'd15 : 64'(frame_q.size());
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_irdy"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_sum0"}, 64'(out_sum), 64'd0);
    check_eq({tag, "_cnt0"}, 64'(out_count), 64'd0);
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every beat after the first, 2 random.
  task automatic run_frame(input string tag, input int gap_mode, input int hold,
                           input bit offer, input logic [31:0] offer_val);
    logic [63:0] e_sum, e_cnt, e_ovf;
    int n;
    n = frame_q.size();
    model_frame(e_sum, e_cnt, e_ovf);
    for (int i = 0; i < n; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(99) < 30)) begin
        in_valid   = 1'b0;
        in_product = $urandom;
        cyc();
        check_eq({tag, "_gap_ovalid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_gap_sum0"}, 64'(out_sum), 64'd0);
      end
      check_eq({tag, "_irdy"}, 64'(in_ready), 64'd1);
      in_valid   = 1'b1;
      in_product = frame_q[i];
      in_last    = (i == n - 1);
      cyc();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != n - 1) check_eq({tag, "_mid_ovalid"}, 64'(out_valid), 64'd0);
    end
    check_eq({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_irdy_hold"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_sum"}, 64'(out_sum), e_sum);
    check_eq({tag, "_cnt"}, 64'(out_count), e_cnt);
    check_eq({tag, "_ovf"}, 64'(out_overflow), e_ovf);
    for (int h = 0; h < hold; h++) begin
      out_ready  = 1'b0;
      in_valid   = 1'($urandom_range(1));
      in_product = $urandom;
      in_last    = 1'($urandom_range(1));
      cyc();
      check_eq({tag, "_hold_ovalid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_irdy"}, 64'(in_ready), 64'd0);
      check_eq({tag, "_hold_sum"}, 64'(out_sum), e_sum);
      check_eq({tag, "_hold_cnt"}, 64'(out_count), e_cnt);
      check_eq({tag, "_hold_ovf"}, 64'(out_overflow), e_ovf);
    end
    out_ready  = 1'b1;
    in_valid   = offer;
    in_product = offer_val;
    in_last    = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_idle_outputs({tag, "_exit"});
    if (offer) begin
      // Same beat still offered; it is accepted only now, from Idle.
      cyc();
      in_valid = 1'b0;
      check_eq({tag, "_late_ovalid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_late_sum"}, 64'(out_sum), 64'(offer_val));
      check_eq({tag, "_late_cnt"}, 64'(out_count), 64'd1);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check_eq({tag, "_late_exit"}, 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_product = 32'h1234;
    in_last    = 1'b1;
    out_ready  = 1'b0;
    cyc();
    cyc();
    check_idle_outputs("reset");
    check_eq("reset_ovf", 64'(out_overflow), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    check_idle_outputs("post_reset");

    frame_q = '{32'd3, 32'd5, 32'd7};
    run_frame("basic", 0, 0, 1'b0, 32'd0);

    frame_q = '{32'hFFFE_0001};
    run_frame("hold4", 0, 4, 1'b0, 32'd0);

    frame_q = '{32'hFFFF_FFFF, 32'h2};
    run_frame("ovf", 0, 1, 1'b0, 32'd0);
    frame_q = '{32'd4};
    run_frame("ovf_clear", 0, 0, 1'b0, 32'd0);

    frame_q = '{32'h1_0000, 32'h1_0000, 32'h1_0000};
    run_frame("gaps", 1, 0, 1'b0, 32'd0);

    // Abort a frame with reset, while a last beat is also offered.
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_product = 32'd100;
    cyc();
    in_product = 32'd200;
    cyc();
    rst        = 1'b1;
    in_product = 32'd77;
    in_last    = 1'b1;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_idle_outputs("abort");
    cyc();
    check_idle_outputs("abort_idle");
    frame_q = '{32'd9};
    run_frame("after_abort", 0, 0, 1'b0, 32'd0);

    frame_q = '{32'd11, 32'd22};
    run_frame("exit_offer", 0, 2, 1'b1, 32'hABCD);

    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(32'd1);
    run_frame("cnt_sat", 0, 0, 1'b0, 32'd0);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3) == 0) frame_q.push_back(32'hFFFF_FFFF - $urandom_range(255));
        else frame_q.push_back($urandom_range(32'h00FF_FFFF));
      end
      run_frame("rand", 2, $urandom_range(3), 1'($urandom_range(1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
